mc_datapath_p: RTL and testbench

- Parametrised multicycle MIPS-subset datapath; the next generation of the 8-bit byte-fetch datapath.
- Scales data/address width to WIDTH (8/16/32).
- Owns the memory port through an internal access sequencer with a ready handshake:
  - 32-bit instruction fetch in 32/WIDTH beats.
  - Single-beat data loads/stores.
- Sits between the multicycle controller (drives the mux/ALU selects) and a variable-latency memory.

---
 rtl/mc_datapath_p.sv | 213 +++++++++++++++++++++
 tb/tb_mc_datapath_p.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_datapath_p.sv
// rtl/mc_datapath_p.sv - parametrised multicycle MIPS-subset datapath with memory access sequencer
// Purpose: WIDTH-bit multicycle datapath that owns the memory port through an
//    IDLE/FETCH/DREAD/DWRITE sequencer. A 32-bit instruction is fetched in
//    32/WIDTH beats; data loads and stores are single beats.
// Ports:
//    clk, reset            clock, asynchronous active-low reset
//    mem_rdata, mem_ready  memory read data and beat completion
//    mem_rd, mem_wr        memory read/write requests
//    adr, writedata        byte address and store data
//    fetch_start/done      instruction fetch request and completion pulse
//    memread, memwrite     data load/store requests
//    mem_done, busy        data access completion pulse, sequencer not idle
//    alusrca..alucont      controller selects and enables
//    zero, instr           ALU result is zero, instruction register
module mc_datapath_p #(
   parameter int               WIDTH    = 8,
   parameter int               REGBITS  = 3,
   parameter logic [WIDTH-1:0] RESET_PC = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] mem_rdata,
   input  logic             mem_ready,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [WIDTH-1:0] adr,
   output logic [WIDTH-1:0] writedata,
   input  logic             fetch_start,
   output logic             fetch_done,
   input  logic             memread,
   input  logic             memwrite,
   output logic             mem_done,
   output logic             busy,
   input  logic             alusrca,
   input  logic             memtoreg,
   input  logic             iord,
   input  logic             pcen,
   input  logic             regwrite,
   input  logic             regdst,
   input  logic [1:0]       pcsource,
   input  logic [1:0]       alusrcb,
   input  logic [2:0]       alucont,
   output logic             zero,
   output logic [31:0]      instr
);

   localparam int               BEATS     = 32 / WIDTH;
   localparam int               KW        = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [KW-1:0]    LAST_BEAT = KW'(BEATS - 1);
   localparam logic [WIDTH-1:0] BYTES     = WIDTH'(WIDTH / 8);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DREAD, S_DWRITE} state_t;

   state_t             r_state, w_next_state;
   logic [KW-1:0]      r_beat;
   logic [WIDTH-1:0]   r_pc, r_mdr, r_a, r_writedata, r_aluout;
   logic [31:0]        r_instr;
   logic               r_fetch_done, r_mem_done;
   logic [WIDTH-1:0]   r_rf [2**REGBITS];

   logic               w_fetch_beat, w_fetch_last, w_data_beat;
   logic [REGBITS-1:0] w_ra1, w_ra2, w_wa;
   logic [WIDTH-1:0]   w_rd1, w_rd2, w_wd, w_imm, w_immx4;
   logic [WIDTH-1:0]   w_src1, w_src2, w_aluresult, w_jtarget, w_nextpc;
   logic [27:0]        w_jfull;
   logic               w_unused;

   // ---------------- sequencer FSM ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE: begin
            // fetch > read > write; losers in the same cycle are dropped
            if (fetch_start)   w_next_state = S_FETCH;
            else if (memread)  w_next_state = S_DREAD;
            else if (memwrite) w_next_state = S_DWRITE;
         end
         S_FETCH:  if (w_fetch_last) w_next_state = S_IDLE;
         S_DREAD,
         S_DWRITE: if (mem_ready) w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // requests depend only on the state register, so they never glitch on inputs
   always_comb begin
      mem_rd = (r_state == S_FETCH) || (r_state == S_DREAD);
      mem_wr = (r_state == S_DWRITE);
      busy   = (r_state != S_IDLE);
      case (r_state)
         S_IDLE:  adr = iord ? r_aluout : r_pc;
         S_FETCH: adr = r_pc;
         default: adr = r_aluout;
      endcase
   end

   assign w_fetch_beat = (r_state == S_FETCH) && mem_ready;
   assign w_fetch_last = w_fetch_beat && (r_beat == LAST_BEAT);
   assign w_data_beat  = ((r_state == S_DREAD) || (r_state == S_DWRITE)) && mem_ready;

   // ---------------- sequencer-owned state ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_beat       <= '0;
         r_pc         <= RESET_PC;
         r_instr      <= '0;
         r_mdr        <= '0;
         r_fetch_done <= 1'b0;
         r_mem_done   <= 1'b0;
      end else begin
         r_fetch_done <= w_fetch_last;
         r_mem_done   <= w_data_beat;
         if (w_fetch_beat) begin
            // little-endian beat order: beat k fills instr lane k
            r_instr[int'(r_beat)*WIDTH +: WIDTH] <= mem_rdata;
            r_pc   <= r_pc + BYTES;
            r_beat <= w_fetch_last ? '0 : r_beat + 1'b1;
         end else if ((r_state == S_IDLE) && pcen) begin
            r_pc <= w_nextpc;
         end
         if ((r_state == S_DREAD) && mem_ready) r_mdr <= mem_rdata;
      end
   end

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_a         <= '0;
         r_writedata <= '0;
         r_aluout    <= '0;
      end else begin
         r_a      <= w_rd1;
         r_aluout <= w_aluresult;
         // store data must stay put while the write beat is outstanding
         if (r_state != S_DWRITE) r_writedata <= w_rd2;
      end
   end

   // ---------------- register file (not reset, r0 hardwired to 0) ----------------
   assign w_ra1 = r_instr[21 +: REGBITS];
   assign w_ra2 = r_instr[16 +: REGBITS];
   assign w_wa  = regdst ? r_instr[11 +: REGBITS] : r_instr[16 +: REGBITS];
   assign w_wd  = memtoreg ? r_mdr : r_aluout;

   always_ff @(posedge clk) begin
      if (regwrite && (w_wa != '0)) r_rf[w_wa] <= w_wd;
   end

   assign w_rd1 = (w_ra1 == '0) ? '0 : r_rf[w_ra1];
   assign w_rd2 = (w_ra2 == '0) ? '0 : r_rf[w_ra2];

   // ---------------- ALU and operand muxes ----------------
   // the width cast sign-extends for WIDTH>16 and keeps the low bits for WIDTH<16
   assign w_imm   = WIDTH'($signed(r_instr[15:0]));
   assign w_immx4 = w_imm << 2;
   assign w_src1  = alusrca ? r_a : r_pc;

   always_comb begin
      case (alusrcb)
         2'b00:   w_src2 = r_writedata;
         2'b01:   w_src2 = BYTES;
         2'b10:   w_src2 = w_imm;
         default: w_src2 = w_immx4;
      endcase
   end

   always_comb begin
      case (alucont)
         3'b000:  w_aluresult = w_src1 & w_src2;
         3'b001:  w_aluresult = w_src1 | w_src2;
         3'b010:  w_aluresult = w_src1 + w_src2;
         3'b110:  w_aluresult = w_src1 - w_src2;
         3'b111:  w_aluresult = ($signed(w_src1) < $signed(w_src2)) ? WIDTH'(1) : '0;
         default: w_aluresult = '0;
      endcase
   end

   assign zero = (w_aluresult == '0);

   // ---------------- next-pc ----------------
   assign w_jfull = {r_instr[25:0], 2'b00};

   generate
      if (WIDTH == 32) begin : g_jtarget_32
         assign w_jtarget = {r_pc[31:28], w_jfull};
      end else begin : g_jtarget_narrow
         assign w_jtarget = w_jfull[WIDTH-1:0];
      end
   endgenerate

   always_comb begin
      case (pcsource)
         2'b00:   w_nextpc = w_aluresult;
         2'b01:   w_nextpc = r_aluout;
         2'b10:   w_nextpc = w_jtarget;
         default: w_nextpc = '0;
      endcase
   end

   // instruction bits beyond the decoded fields are intentionally ignored
   assign w_unused = ^{r_instr, w_jfull};

   assign instr      = r_instr;
   assign writedata  = r_writedata;
   assign fetch_done = r_fetch_done;
   assign mem_done   = r_mem_done;

endmodule

// File: tb/tb_mc_datapath_p.sv
// tb/tb_mc_datapath_p.sv - directed-vector bench for mc_datapath_p at WIDTH 8 and 16
module tb_mc_datapath_p;

   logic clk = 1'b0;
   logic reset;
   logic memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite, regdst;
   logic [1:0] pcsource, alusrcb;
   logic [2:0] alucont;

   logic [7:0]  mem_rdata8, adr8, writedata8;
   logic        mem_ready8, mem_rd8, mem_wr8, fetch_start8, fetch_done8, mem_done8, busy8, zero8;
   logic [31:0] instr8;

   logic [15:0] mem_rdata16, adr16, writedata16;
   logic        mem_ready16, mem_rd16, mem_wr16, fetch_start16, fetch_done16, mem_done16, busy16, zero16;
   logic [31:0] instr16;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0]  mem8 [256];
   logic [15:0] mem16 [128];
   int   lat8, lat16, w8, w16;
   bit   auto8, auto16, force8;
   logic [7:0] force_data8, wr_adr8;
   int   n_rd8, n_wr8, n_fd8, n_md8, n_rd16, n_busy16, n_fd16;

   mc_datapath_p #(.WIDTH(8), .REGBITS(3)) u_dut8 (
      .clk(clk), .reset(reset), .mem_rdata(mem_rdata8), .mem_ready(mem_ready8),
      .mem_rd(mem_rd8), .mem_wr(mem_wr8), .adr(adr8), .writedata(writedata8),
      .fetch_start(fetch_start8), .fetch_done(fetch_done8), .memread(memread),
      .memwrite(memwrite), .mem_done(mem_done8), .busy(busy8), .alusrca(alusrca),
      .memtoreg(memtoreg), .iord(iord), .pcen(pcen), .regwrite(regwrite), .regdst(regdst),
      .pcsource(pcsource), .alusrcb(alusrcb), .alucont(alucont), .zero(zero8), .instr(instr8)
   );

   mc_datapath_p #(.WIDTH(16), .REGBITS(3)) u_dut16 (
      .clk(clk), .reset(reset), .mem_rdata(mem_rdata16), .mem_ready(mem_ready16),
      .mem_rd(mem_rd16), .mem_wr(mem_wr16), .adr(adr16), .writedata(writedata16),
      .fetch_start(fetch_start16), .fetch_done(fetch_done16), .memread(1'b0),
      .memwrite(1'b0), .mem_done(mem_done16), .busy(busy16), .alusrca(alusrca),
      .memtoreg(memtoreg), .iord(iord), .pcen(pcen), .regwrite(regwrite), .regdst(regdst),
      .pcsource(pcsource), .alusrcb(alusrcb), .alucont(alucont), .zero(zero16), .instr(instr16)
   );

   always #5 clk = ~clk;

   // one clock: sample at the falling edge, then play memory for both DUTs
   task automatic cyc();
      @(negedge clk);
      if (mem_rd8) n_rd8++;
      if (mem_wr8) n_wr8++;
      if (fetch_done8) n_fd8++;
      if (mem_done8) n_md8++;
      if (mem_rd16) n_rd16++;
      if (busy16) n_busy16++;
      if (fetch_done16) n_fd16++;
      if (auto8 && (mem_rd8 || mem_wr8)) begin
         if (w8 >= lat8) begin
            mem_ready8 = 1'b1;
            mem_rdata8 = mem8[adr8];
            if (mem_wr8) begin
               mem8[adr8] = writedata8;
               wr_adr8 = adr8;
            end
            w8 = 0;
         end else begin
            mem_ready8 = 1'b0;
            mem_rdata8 = 8'h00;
            w8++;
         end
      end else begin
         mem_ready8 = force8;
         mem_rdata8 = force_data8;
         w8 = 0;
      end
      if (auto16 && mem_rd16) begin
         if (w16 >= lat16) begin
            mem_ready16 = 1'b1;
            mem_rdata16 = mem16[adr16[7:1]];
            w16 = 0;
         end else begin
            mem_ready16 = 1'b0;
            mem_rdata16 = 16'h0000;
            w16++;
         end
      end else begin
         mem_ready16 = 1'b0;
         mem_rdata16 = 16'h0000;
         w16 = 0;
      end
   endtask

   task automatic clr();
      n_rd8 = 0; n_wr8 = 0; n_fd8 = 0; n_md8 = 0;
      n_rd16 = 0; n_busy16 = 0; n_fd16 = 0;
   endtask

   // park pc at 0 and fetch a word from there with a zero-latency memory
   task automatic load_instr8(input logic [31:0] word);
      int start;
      pcsource = 2'b11; pcen = 1'b1;
      cyc();
      pcen = 1'b0;
      mem8[0] = word[7:0]; mem8[1] = word[15:8]; mem8[2] = word[23:16]; mem8[3] = word[31:24];
      lat8 = 0;
      start = n_fd8;
      fetch_start8 = 1'b1;
      cyc();
      fetch_start8 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (n_fd8 != start) break;
         cyc();
      end
   endtask

   task automatic set_pc0();
      pcsource = 2'b11; pcen = 1'b1;
      cyc();
      pcen = 1'b0;
   endtask

   task automatic test_reset();
      cyc(); cyc();
      vectors++; if ({mem_rd8, mem_wr8, busy8, fetch_done8, mem_done8} !== 5'b0) begin miscompares++; $display("FAIL reset_ctrl8 got %b want 00000", {mem_rd8, mem_wr8, busy8, fetch_done8, mem_done8}); end
      vectors++; if (instr8 !== 32'h0) begin miscompares++; $display("FAIL reset_instr8 got %h want 00000000", instr8); end
      vectors++; if (adr8 !== 8'h00) begin miscompares++; $display("FAIL reset_pc8 got %h want 00", adr8); end
      vectors++; if (writedata8 !== 8'h00) begin miscompares++; $display("FAIL reset_wdata8 got %h want 00", writedata8); end
      vectors++; if ({mem_rd16, busy16, fetch_done16} !== 3'b0) begin miscompares++; $display("FAIL reset_ctrl16 got %b want 000", {mem_rd16, busy16, fetch_done16}); end
      reset = 1'b1;
      cyc();
   endtask

   task automatic test_fetch8();
      mem8[0] = 8'h20; mem8[1] = 8'h00; mem8[2] = 8'h22; mem8[3] = 8'h8C;
      lat8 = 1; iord = 1'b0;
      clr();
      fetch_start8 = 1'b1;
      cyc();
      fetch_start8 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (n_fd8 != 0) break;
         cyc();
      end
      cyc(); cyc(); cyc();
      vectors++; if (instr8 !== 32'h8C220020) begin miscompares++; $display("FAIL fetch8_instr got %h want 8c220020", instr8); end
      vectors++; if (adr8 !== 8'h04) begin miscompares++; $display("FAIL fetch8_pc got %h want 04", adr8); end
      vectors++; if (n_rd8 != 8) begin miscompares++; $display("FAIL fetch8_rd_cycles got %0d want 8", n_rd8); end
      vectors++; if (n_fd8 != 1) begin miscompares++; $display("FAIL fetch8_done_pulses got %0d want 1", n_fd8); end
      vectors++; if (busy8 !== 1'b0) begin miscompares++; $display("FAIL fetch8_busy_after got %b want 0", busy8); end
   endtask

   task automatic test_fetch16();
      mem16[0] = 16'h0020; mem16[1] = 16'h8C22;
      lat16 = 3; iord = 1'b0;
      clr();
      fetch_start16 = 1'b1;
      cyc();
      fetch_start16 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (n_fd16 != 0) break;
         cyc();
      end
      cyc(); cyc();
      vectors++; if (instr16 !== 32'h8C220020) begin miscompares++; $display("FAIL fetch16_instr got %h want 8c220020", instr16); end
      vectors++; if (adr16 !== 16'h0004) begin miscompares++; $display("FAIL fetch16_pc got %h want 0004", adr16); end
      vectors++; if (n_rd16 != 8) begin miscompares++; $display("FAIL fetch16_rd_cycles got %0d want 8", n_rd16); end
      vectors++; if (n_busy16 != 8) begin miscompares++; $display("FAIL fetch16_busy_cycles got %0d want 8", n_busy16); end
      vectors++; if (n_fd16 != 1) begin miscompares++; $display("FAIL fetch16_done_pulses got %0d want 1", n_fd16); end
   endtask

   task automatic test_reset_mid_fetch();
      mem8[4] = 8'h11; mem8[5] = 8'h22; mem8[6] = 8'h33; mem8[7] = 8'h44;
      lat8 = 1;
      clr();
      fetch_start8 = 1'b1;
      cyc();
      fetch_start8 = 1'b0;
      cyc(); cyc();
      // first beat captured, second beat outstanding
      reset = 1'b0;
      #1;
      vectors++; if ({mem_rd8, mem_wr8, busy8, fetch_done8, mem_done8} !== 5'b0) begin miscompares++; $display("FAIL midrst_ctrl got %b want 00000", {mem_rd8, mem_wr8, busy8, fetch_done8, mem_done8}); end
      vectors++; if (instr8 !== 32'h0) begin miscompares++; $display("FAIL midrst_instr got %h want 00000000", instr8); end
      vectors++; if (adr8 !== 8'h00) begin miscompares++; $display("FAIL midrst_pc got %h want 00", adr8); end
      auto8 = 1'b0; force8 = 1'b1; force_data8 = 8'hEE;
      cyc();
      reset = 1'b1;
      cyc(); cyc(); cyc();
      vectors++; if (instr8 !== 32'h0) begin miscompares++; $display("FAIL midrst_late_ready_instr got %h want 00000000", instr8); end
      vectors++; if (adr8 !== 8'h00) begin miscompares++; $display("FAIL midrst_late_ready_pc got %h want 00", adr8); end
      vectors++; if (n_fd8 != 0 || busy8 !== 1'b0) begin miscompares++; $display("FAIL midrst_late_ready_done got fd=%0d busy=%b want 0 0", n_fd8, busy8); end
      force8 = 1'b0; force_data8 = 8'h00; auto8 = 1'b1;
      cyc();
   endtask

   task automatic test_fetch_priority();
      mem8[0] = 8'h20; mem8[1] = 8'h00; mem8[2] = 8'h22; mem8[3] = 8'h8C;
      lat8 = 1;
      clr();
      fetch_start8 = 1'b1; memread = 1'b1;
      cyc();
      fetch_start8 = 1'b0; memread = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (n_fd8 != 0) break;
         cyc();
      end
      cyc(); cyc(); cyc(); cyc();
      vectors++; if (n_fd8 != 1 || n_md8 != 0) begin miscompares++; $display("FAIL prio_pulses got fd=%0d md=%0d want 1 0", n_fd8, n_md8); end
      vectors++; if (n_rd8 != 8) begin miscompares++; $display("FAIL prio_rd_cycles got %0d want 8", n_rd8); end
      vectors++; if (instr8 !== 32'h8C220020) begin miscompares++; $display("FAIL prio_instr got %h want 8c220020", instr8); end
   endtask

   task automatic test_alu();
      // rs=1 rt=2 rd=1 imm=7f
      load_instr8(32'h0022087F);
      vectors++; if (instr8 !== 32'h0022087F) begin miscompares++; $display("FAIL alu_fetch_a got %h want 0022087f", instr8); end
      set_pc0();
      alusrca = 1'b0; alusrcb = 2'b10; alucont = 3'b010;
      cyc();
      regdst = 1'b1; memtoreg = 1'b0; regwrite = 1'b1;
      cyc();
      regwrite = 1'b0; alusrcb = 2'b01;
      cyc();
      regdst = 1'b0; regwrite = 1'b1;
      cyc();
      regwrite = 1'b0;
      alusrca = 1'b1; alusrcb = 2'b00; alucont = 3'b010;
      cyc();
      vectors++; if (zero8 !== 1'b0) begin miscompares++; $display("FAIL add_zero got %b want 0", zero8); end
      vectors++; if (writedata8 !== 8'h01) begin miscompares++; $display("FAIL add_wdata got %h want 01", writedata8); end
      cyc();
      iord = 1'b1; #1;
      vectors++; if (adr8 !== 8'h80) begin miscompares++; $display("FAIL add_aluout got %h want 80", adr8); end
      iord = 1'b0;
      pcsource = 2'b01; pcen = 1'b1;
      cyc();
      pcen = 1'b0;
      alusrca = 1'b0; alusrcb = 2'b01; alucont = 3'b111;
      #1;
      vectors++; if (zero8 !== 1'b0) begin miscompares++; $display("FAIL slt_zero got %b want 0", zero8); end
      cyc();
      iord = 1'b1; #1;
      vectors++; if (adr8 !== 8'h01) begin miscompares++; $display("FAIL slt_result got %h want 01", adr8); end
      iord = 1'b0;
      alucont = 3'b000; #1;
      vectors++; if (zero8 !== 1'b1) begin miscompares++; $display("FAIL and_zero got %b want 1", zero8); end
      alusrcb = 2'b10; alucont = 3'b001; #1;
      vectors++; if (zero8 !== 1'b0) begin miscompares++; $display("FAIL or_zero got %b want 0", zero8); end
      alucont = 3'b011; #1;
      vectors++; if (zero8 !== 1'b1) begin miscompares++; $display("FAIL undef_op_zero got %b want 1", zero8); end
      // rs=1 rt=1 rd=1 imm=5a
      load_instr8(32'h0021085A);
      vectors++; if (instr8 !== 32'h0021085A) begin miscompares++; $display("FAIL alu_fetch_b got %h want 0021085a", instr8); end
      alusrca = 1'b1; alusrcb = 2'b00; alucont = 3'b110;
      cyc();
      vectors++; if (zero8 !== 1'b1) begin miscompares++; $display("FAIL sub_zero got %b want 1", zero8); end
   endtask

   task automatic test_store();
      set_pc0();
      alusrca = 1'b0; alusrcb = 2'b10; alucont = 3'b010;
      cyc();
      regdst = 1'b1; memtoreg = 1'b0; regwrite = 1'b1;
      cyc();
      regwrite = 1'b0;
      // rs=3 rt=1 rd=3 imm=04
      load_instr8(32'h00611804);
      vectors++; if (instr8 !== 32'h00611804) begin miscompares++; $display("FAIL store_fetch got %h want 00611804", instr8); end
      set_pc0();
      alusrca = 1'b0; alusrcb = 2'b11; alucont = 3'b010;
      cyc();
      vectors++; if (writedata8 !== 8'h5A) begin miscompares++; $display("FAIL store_wdata got %h want 5a", writedata8); end
      mem8[8'h10] = 8'h00; wr_adr8 = 8'h00; lat8 = 1;
      clr();
      memwrite = 1'b1;
      cyc();
      memwrite = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (n_md8 != 0) break;
         cyc();
      end
      cyc(); cyc();
      vectors++; if (n_wr8 != 2) begin miscompares++; $display("FAIL store_wr_cycles got %0d want 2", n_wr8); end
      vectors++; if (n_md8 != 1) begin miscompares++; $display("FAIL store_done_pulses got %0d want 1", n_md8); end
      vectors++; if (wr_adr8 !== 8'h10) begin miscompares++; $display("FAIL store_adr got %h want 10", wr_adr8); end
      vectors++; if (mem8[8'h10] !== 8'h5A) begin miscompares++; $display("FAIL store_data got %h want 5a", mem8[8'h10]); end
   endtask

   task automatic test_load_r0();
      mem8[8'h10] = 8'hA5; lat8 = 1;
      clr();
      memread = 1'b1;
      cyc();
      memread = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (n_md8 != 0) break;
         cyc();
      end
      vectors++; if (n_md8 != 1 || n_rd8 != 2) begin miscompares++; $display("FAIL load_handshake got md=%0d rd=%0d want 1 2", n_md8, n_rd8); end
      memtoreg = 1'b1; regdst = 1'b1; regwrite = 1'b1;
      cyc();
      regwrite = 1'b0; memtoreg = 1'b0;
      alusrca = 1'b1; alusrcb = 2'b10; alucont = 3'b001;
      cyc(); cyc();
      iord = 1'b1; #1;
      vectors++; if (adr8 !== 8'hA5) begin miscompares++; $display("FAIL load_r3 got %h want a5", adr8); end
      iord = 1'b0;
      // rs=0 rt=0 rd=0 imm=33
      load_instr8(32'h00000033);
      vectors++; if (instr8 !== 32'h00000033) begin miscompares++; $display("FAIL r0_fetch got %h want 00000033", instr8); end
      alusrca = 1'b0; alusrcb = 2'b10; alucont = 3'b001;
      cyc();
      regdst = 1'b1; regwrite = 1'b1;
      cyc();
      regwrite = 1'b0;
      alusrca = 1'b1; alusrcb = 2'b00; alucont = 3'b010;
      cyc();
      vectors++; if (zero8 !== 1'b1 || writedata8 !== 8'h00) begin miscompares++; $display("FAIL r0_read got zero=%b wdata=%h want 1 00", zero8, writedata8); end
      cyc();
      iord = 1'b1; #1;
      vectors++; if (adr8 !== 8'h00) begin miscompares++; $display("FAIL r0_sum got %h want 00", adr8); end
      iord = 1'b0;
   endtask

   initial begin
      reset = 1'b0;
      memread = 0; memwrite = 0; alusrca = 0; memtoreg = 0; iord = 0; pcen = 0;
      regwrite = 0; regdst = 0; pcsource = 2'b00; alusrcb = 2'b00; alucont = 3'b000;
      fetch_start8 = 0; fetch_start16 = 0;
      mem_ready8 = 0; mem_rdata8 = 0; mem_ready16 = 0; mem_rdata16 = 0;
      auto8 = 1; auto16 = 1; force8 = 0; force_data8 = 0; wr_adr8 = 0;
      lat8 = 1; lat16 = 1; w8 = 0; w16 = 0;
      for (int i = 0; i < 256; i++) mem8[i] = 8'h00;
      for (int i = 0; i < 128; i++) mem16[i] = 16'h0000;
      clr();
      test_reset();
      test_fetch8();
      test_fetch16();
      test_reset_mid_fetch();
      test_fetch_priority();
      test_alu();
      test_store();
      test_load_r0();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
